imem_loader: RTL

Boot-time program loader that writes the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake and packs every four bytes into one 32-bit instruction word. Each word goes out on a single-cycle write port into the 64-word instruction store, starting at word 0. While loading, the loader holds the processor core in reset, and releases it once the requested number of words has been written.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
package imem_pkg;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam logic [AW:0] MAX_COUNT = 7'd64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words: byte k lands in bits [8k+7:8k].
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        last_byte
);
  logic [1:0]  cnt_r;
  logic [31:0] word_r;

  // byte lane counter and assembly register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (clear) begin
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (accept) begin
      word_r[{cnt_r, 3'b000} +: 8] <= byte_data;
      cnt_r                        <= cnt_r + 2'd1;
    end else begin
      cnt_r  <= cnt_r;
      word_r <= word_r;
    end
  end

  assign word      = word_r;
  assign last_byte = (cnt_r == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into 32-bit words, writes them to instruction memory
// from word 0 upward, and holds the core in reset until the load completes.
module imem_loader
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          core_rst_n
);
  state_t        state_r, next_s;
  logic [AW:0]   count_r;
  logic [AW-1:0] waddr_r;
  logic          byte_ready_r, we_r, busy_r, done_r, err_r, core_rst_n_r;
  logic          legal_s, idle_like_s, load_start_s, bad_start_s;
  logic          accept_s, last_byte_s, last_addr_s;
  logic [31:0]   word_s;

  assign legal_s      = (word_count != 7'd0) && (word_count <= MAX_COUNT);
  assign idle_like_s  = (state_r == IDLE) || (state_r == DONE);
  assign load_start_s = start && legal_s && idle_like_s;
  assign bad_start_s  = start && !legal_s && idle_like_s;
  assign accept_s     = byte_valid && byte_ready_r;
  assign last_addr_s  = ({1'b0, waddr_r} == (count_r - 7'd1));

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load_start_s),
    .accept    (accept_s),
    .byte_data (byte_data),
    .word      (word_s),
    .last_byte (last_byte_s)
  );

  // next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_start_s) next_s = LOAD;
        else              next_s = IDLE;
      end
      LOAD: begin
        if (accept_s && last_byte_s) next_s = WRITE;
        else                         next_s = LOAD;
      end
      WRITE: begin
        if (last_addr_s) next_s = DONE;
        else             next_s = LOAD;
      end
      DONE: begin
        if (load_start_s)     next_s = LOAD;
        else if (bad_start_s) next_s = IDLE;
        else                  next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // state, address/count tracking and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      count_r      <= 7'd0;
      waddr_r      <= 6'd0;
      byte_ready_r <= 1'b0;
      we_r         <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      core_rst_n_r <= 1'b0;
    end else begin
      state_r      <= next_s;
      byte_ready_r <= (next_s == LOAD);
      we_r         <= (next_s == WRITE);
      busy_r       <= (next_s == LOAD) || (next_s == WRITE);
      done_r       <= (next_s == DONE);
      core_rst_n_r <= (next_s == DONE);
      if (load_start_s) begin
        count_r <= word_count;
        waddr_r <= 6'd0;
        err_r   <= 1'b0;
      end else if (bad_start_s) begin
        count_r <= count_r;
        waddr_r <= waddr_r;
        err_r   <= 1'b1;
      end else if ((state_r == WRITE) && (next_s == LOAD)) begin
        count_r <= count_r;
        waddr_r <= waddr_r + 6'd1;
        err_r   <= err_r;
      end else begin
        count_r <= count_r;
        waddr_r <= waddr_r;
        err_r   <= err_r;
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign we         = we_r;
  assign waddr      = waddr_r;
  assign wdata      = word_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign core_rst_n = core_rst_n_r;
endmodule
